pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Sequences the 100 MHz -> 50 MHz system PLL: pulses its reset, waits for lock,
//  qualifies lock stability, then releases reset to the 50 MHz user logic.
//  Runs on the free-running reference clock, so it works while the PLL is unlocked.
//  On loss of lock it re-asserts downstream reset and restarts the PLL, with bounded retries.
// PARAMETERS
//  RST_CYCLES     16      cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT   100000  cycles to wait for locked after pll_rst release before retry
//  STABLE_CYCLES  1024    consecutive synchronized-locked cycles required before RUN
//  MAX_RETRIES    4       failed attempts tolerated before FAIL state
//  CNT_W          20      width of shared cycle counter (must hold max of the above)
// PORTS
//  refclk          in   1      100 MHz reference clock, free-running
//  reset_n         in   1      async active-low reset
//  pll_locked      in   1      PLL locked, asynchronous to refclk
//  soft_reset_req  in   1      1-cycle pulse: restart full sequence
//  pll_rst         out  1      reset to PLL, active-high
//  sys_reset_n     out  1      reset for user logic, active-low (consumer re-synchronizes)
//  pll_ready       out  1      high only in RUN
//  fail            out  1      sticky: retries exhausted
//  relock_count    out  8      saturating count of lock losses seen in RUN
//  state_dbg       out  3      current state encoding
// BEHAVIOUR
//  - pll_locked passes a 2-flop synchronizer (lk_s); all decisions use lk_s (+2 cycles latency).
//  - Reset (reset_n=0, async): state=PLL_RST, cnt=0, retries=0, pll_rst=1,
//    sys_reset_n=0, pll_ready=0, fail=0, relock_count=0, sync flops=0.
//  - States (state_dbg): PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
//  - PLL_RST: pll_rst=1; cnt counts 0..RST_CYCLES-1, then cnt=0 -> WAIT_LOCK.
//    pll_rst is high for exactly RST_CYCLES cycles.
//  - WAIT_LOCK: pll_rst=0. lk_s=1 -> STABLE (cnt=0).
//    cnt reaches LOCK_TIMEOUT-1 without lock -> retries+1:
//    if new retries==MAX_RETRIES -> FAIL, else -> PLL_RST.
//  - STABLE: lk_s=1 increments cnt; at cnt==STABLE_CYCLES-1 -> RUN.
//    lk_s=0 at any point -> back to WAIT_LOCK with cnt=0; timeout restarts, retries unchanged.
//  - RUN: sys_reset_n=1, pll_ready=1 (registered, first cycle in RUN); retries cleared to 0.
//    lk_s=0 -> relock_count+1 (saturates at 255) -> PLL_RST.
//    sys_reset_n and pll_ready drop on the cycle after lk_s falls.
//  - FAIL: pll_rst=0, sys_reset_n=0, fail=1, stays until reset_n or soft_reset_req.
//  - soft_reset_req=1 in any state: next state PLL_RST, cnt=0, retries=0, fail cleared.
//    relock_count is NOT cleared. Takes priority over all other transitions that cycle.
//  - sys_reset_n=0 and pll_ready=0 in every state except RUN; outputs are glitch-free
//    (driven straight from flops).
//  - Illegal state encodings recover to PLL_RST.
// TESTING
//  1 Reset release; pll_locked rises 50 cycles after pll_rst falls ->
//    pll_rst high 16 cycles; sys_reset_n=1 at ~16+50+2+1024 cycles; pll_ready=1.
//  2 In STABLE, drop pll_locked for 3 cycles at cnt=500 ->
//    return to WAIT_LOCK; RUN reached 1024 cycles after lock resumes; retries=0.
//  3 In RUN, drop pll_locked ->
//    sys_reset_n=0 within 3 refclk cycles; pll_rst pulses 16 cycles; relock_count=1.
//  4 pll_locked held 0 with LOCK_TIMEOUT=200 ->
//    4 pll_rst pulses, then FAIL with fail=1 and state_dbg=4; pll_rst stays 0.
//  5 soft_reset_req in RUN and in FAIL ->
//    PLL_RST next cycle, fail=0, relock_count unchanged.
//  6 Force 300 lock losses in RUN -> relock_count saturates at 255.
//    Assert reset_n mid-STABLE -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock sequencer on the free-running reference clock
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 20
) (
    input  logic       refclk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       pll_ready,
    output logic       fail,
    output logic [7:0] relock_count,
    output logic [2:0] state_dbg
);
    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    localparam int RET_W = $clog2(MAX_RETRIES + 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_MAX     = RET_W'(MAX_RETRIES);

    logic             lk_meta_q, lk_meta_d;
    logic             lk_s_q, lk_s_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RET_W-1:0] retries_q, retries_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_reset_n_q, sys_reset_n_d;
    logic             pll_ready_q, pll_ready_d;
    logic             fail_q, fail_d;
    logic [7:0]       relock_count_q, relock_count_d;

    always_comb begin
        lk_meta_d      = pll_locked;
        lk_s_d         = lk_meta_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        retries_d      = retries_q;
        relock_count_d = relock_count_q;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lk_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d     = '0;
                    retries_d = retries_q + RET_W'(1);
                    state_d   = (retries_d == RET_MAX) ? ST_FAIL : ST_PLL_RST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                // A lock glitch restarts qualification without consuming a retry
                if (!lk_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                retries_d = '0;
                if (!lk_s_q) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                    if (relock_count_q != 8'hFF) begin
                        relock_count_d = relock_count_q + 8'd1;
                    end
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d   = ST_PLL_RST;
                cnt_d     = '0;
                retries_d = '0;
            end
        endcase

        if (soft_reset_req) begin
            state_d        = ST_PLL_RST;
            cnt_d          = '0;
            retries_d      = '0;
            relock_count_d = relock_count_q;
        end

        // Outputs are registered from the next state so they align with state_q
        pll_rst_d     = (state_d == ST_PLL_RST);
        sys_reset_n_d = (state_d == ST_RUN);
        pll_ready_d   = (state_d == ST_RUN);
        fail_d        = (state_d == ST_FAIL);
    end

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            lk_meta_q      <= 1'b0;
            lk_s_q         <= 1'b0;
            state_q        <= ST_PLL_RST;
            cnt_q          <= '0;
            retries_q      <= '0;
            pll_rst_q      <= 1'b1;
            sys_reset_n_q  <= 1'b0;
            pll_ready_q    <= 1'b0;
            fail_q         <= 1'b0;
            relock_count_q <= 8'd0;
        end else begin
            lk_meta_q      <= lk_meta_d;
            lk_s_q         <= lk_s_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retries_q      <= retries_d;
            pll_rst_q      <= pll_rst_d;
            sys_reset_n_q  <= sys_reset_n_d;
            pll_ready_q    <= pll_ready_d;
            fail_q         <= fail_d;
            relock_count_q <= relock_count_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_reset_n  = sys_reset_n_q;
    assign pll_ready    = pll_ready_q;
    assign fail         = fail_q;
    assign relock_count = relock_count_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;
    localparam int RST = 16;
    localparam int TO  = 200;
    localparam int S   = 64;
    localparam int MR  = 4;

    logic       refclk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       pll_ready;
    logic       fail;
    logic [7:0] relock_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_relock = 0;
    int exp_pulse_q[$];
    int exp_rise_q[$];
    int hi_cnt = 0;
    logic prev_srn = 1'b0;

    pll_reset_sequencer #(
        .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(S),
        .MAX_RETRIES(MR), .CNT_W(20)
    ) dut (
        .refclk(refclk), .reset_n(reset_n), .pll_locked(pll_locked),
        .soft_reset_req(soft_reset_req), .pll_rst(pll_rst),
        .sys_reset_n(sys_reset_n), .pll_ready(pll_ready), .fail(fail),
        .relock_count(relock_count), .state_dbg(state_dbg)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: pll_rst pulse widths and RUN entry cycles against the scoreboard
    always @(negedge refclk) begin
        if (!reset_n) begin
            hi_cnt = 0;
        end else if (pll_rst) begin
            hi_cnt++;
        end else if (hi_cnt != 0) begin
            if (exp_pulse_q.size() == 0) chk("pulse_unexpected", hi_cnt, 0);
            else chk("pulse_len", hi_cnt, exp_pulse_q.pop_front());
            hi_cnt = 0;
        end
        if (reset_n && sys_reset_n && !prev_srn) begin
            if (exp_rise_q.size() == 0) chk("run_unexpected", cyc, 0);
            else chk("run_rise_cyc", cyc, exp_rise_q.pop_front());
        end
        prev_srn = sys_reset_n;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic wait_until_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound);
        int n = 0;
        while (state_dbg != s && n < bound) begin
            tick(1);
            n++;
        end
        if (state_dbg != s) chk("wait_state_timeout", int'(state_dbg), int'(s));
    endtask

    task automatic do_relock(input bit detail);
        int p;
        tick(1);
        p = cyc;
        pll_locked = 1'b0;
        exp_relock = (exp_relock == 255) ? 255 : exp_relock + 1;
        exp_pulse_q.push_back(RST);
        exp_rise_q.push_back(p + 4 + RST + S);
        tick(2);
        if (detail) chk("t3_srn_still_high", sys_reset_n, 1);
        tick(1);
        if (detail) begin
            chk("t3_srn_low", sys_reset_n, 0);
            chk("t3_ready_low", pll_ready, 0);
            chk("t3_pll_rst", pll_rst, 1);
            chk("t3_relock", relock_count, exp_relock);
        end
        pll_locked = 1'b1;
        wait_until_cyc(p + 4 + RST + S);
        if (detail) chk("t3_run_again", state_dbg, 3);
    endtask

    initial begin
        int r, p, d, x;
        reset_n = 1'b0;
        pll_locked = 1'b0;
        soft_reset_req = 1'b0;
        tick(3);
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_srn", sys_reset_n, 0);
        chk("rst_ready", pll_ready, 0);
        chk("rst_fail", fail, 0);
        chk("rst_relock", relock_count, 0);
        chk("rst_state", state_dbg, 0);

        // 1: bring-up, lock arrives 50 cycles after pll_rst falls
        exp_pulse_q.push_back(RST);
        reset_n = 1'b1;
        r = cyc;
        tick(RST - 1);
        chk("t1_pll_rst_last", pll_rst, 1);
        tick(1);
        chk("t1_pll_rst_off", pll_rst, 0);
        chk("t1_wait_lock", state_dbg, 1);
        tick(50);
        p = cyc;
        pll_locked = 1'b1;
        exp_rise_q.push_back(p + 3 + S);
        wait_until_cyc(p + 2 + S);
        chk("t1_stable_srn", sys_reset_n, 0);
        chk("t1_stable_state", state_dbg, 2);
        tick(1);
        chk("t1_run_srn", sys_reset_n, 1);
        chk("t1_run_ready", pll_ready, 1);
        chk("t1_run_state", state_dbg, 3);

        // 2: lock glitch in the middle of STABLE
        tick(1);
        p = cyc;
        pll_locked = 1'b0;
        exp_relock++;
        exp_pulse_q.push_back(RST);
        tick(3);
        chk("t2_pll_rst_state", state_dbg, 0);
        pll_locked = 1'b1;
        d = p + 48;
        wait_until_cyc(d);
        chk("t2_in_stable", state_dbg, 2);
        pll_locked = 1'b0;
        tick(3);
        chk("t2_back_wait", state_dbg, 1);
        chk("t2_no_rst_pulse", pll_rst, 0);
        pll_locked = 1'b1;
        r = cyc;
        exp_rise_q.push_back(r + 3 + S);
        wait_until_cyc(r + 3 + S);
        chk("t2_run_ready", pll_ready, 1);

        // 3: lock loss in RUN
        do_relock(1'b1);

        // 4: lock never returns -> retries exhausted
        tick(1);
        d = cyc;
        pll_locked = 1'b0;
        exp_relock++;
        for (int i = 0; i < MR; i++) exp_pulse_q.push_back(RST);
        wait_until_cyc(d + 3 + (RST + TO) * MR - 1);
        chk("t4_last_wait", state_dbg, 1);
        tick(1);
        chk("t4_fail_state", state_dbg, 4);
        chk("t4_fail", fail, 1);
        chk("t4_pll_rst", pll_rst, 0);
        chk("t4_srn", sys_reset_n, 0);
        tick(30);
        chk("t4_fail_sticky", fail, 1);
        chk("t4_pll_rst_stays", pll_rst, 0);
        chk("t4_relock", relock_count, exp_relock);

        // 5: soft reset from FAIL and from RUN
        soft_reset_req = 1'b1;
        x = cyc;
        tick(1);
        soft_reset_req = 1'b0;
        chk("t5f_state", state_dbg, 0);
        chk("t5f_fail", fail, 0);
        chk("t5f_pll_rst", pll_rst, 1);
        chk("t5f_relock", relock_count, exp_relock);
        pll_locked = 1'b1;
        exp_pulse_q.push_back(RST);
        exp_rise_q.push_back(x + 1 + RST + 1 + S);
        wait_until_cyc(x + 1 + RST + 1 + S);
        chk("t5f_run", state_dbg, 3);
        tick(5);
        soft_reset_req = 1'b1;
        x = cyc;
        tick(1);
        soft_reset_req = 1'b0;
        chk("t5r_state", state_dbg, 0);
        chk("t5r_srn", sys_reset_n, 0);
        chk("t5r_ready", pll_ready, 0);
        chk("t5r_relock", relock_count, exp_relock);
        exp_pulse_q.push_back(RST);
        exp_rise_q.push_back(x + 1 + RST + 1 + S);
        wait_until_cyc(x + 1 + RST + 1 + S);
        chk("t5r_run", state_dbg, 3);

        // 6: relock_count saturation
        for (int i = 0; i < 300; i++) begin
            do_relock(1'b0);
            if (i == 250) chk("t6_relock_mid", relock_count, exp_relock);
        end
        chk("t6_relock_sat", relock_count, 255);

        // async reset in the middle of STABLE
        tick(1);
        pll_locked = 1'b0;
        exp_pulse_q.push_back(RST);
        tick(3);
        pll_locked = 1'b1;
        wait_state(3'd2, 100);
        tick(5);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_pll_rst", pll_rst, 1);
        chk("ar_srn", sys_reset_n, 0);
        chk("ar_ready", pll_ready, 0);
        chk("ar_fail", fail, 0);
        chk("ar_relock", relock_count, 0);
        chk("ar_state", state_dbg, 0);
        @(posedge refclk);
        #1;
        reset_n = 1'b1;
        r = cyc;
        exp_pulse_q.push_back(RST);
        exp_rise_q.push_back(r + RST + 1 + S);
        wait_until_cyc(r + RST + 1 + S);
        chk("ar_run", state_dbg, 3);
        tick(2);
        chk("pulse_q_drained", exp_pulse_q.size(), 0);
        chk("rise_q_drained", exp_rise_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
